// File: rtl/sdhci_pkg.sv
// ============================================================================
// Module : sdhci_pkg
// Brief  : Shared types and constants for the SD CMD line controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sdhci_pkg;

  typedef enum logic [1:0] {
    RSP_NONE      = 2'd0,
    RSP_R48       = 2'd1,
    RSP_R48_NOCRC = 2'd2,
    RSP_R136      = 2'd3
  } rsp_type_e;

  localparam int c_CMD_FRAME_LEN  = 48;
  localparam int c_R136_FRAME_LEN = 136;
  // Leading bits of a 48-bit frame that the CRC7 covers.
  localparam int c_CRC_BITS       = 40;
  // x^7 + x^3 + 1, x^7 implied by the shift-out.
  localparam logic [6:0] c_CRC7_POLY = 7'h09;

endpackage

`default_nettype wire

// File: rtl/sdhci_crc7.sv
// ============================================================================
// Module : sdhci_crc7
// Brief  : Serial CRC7 generator, MSB-first, with synchronous clear.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sdhci_crc7
  import sdhci_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q, crc_d;
  logic       w_fb;

  assign w_fb  = bit_i ^ crc_q[6];
  assign crc_o = crc_q;

  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = '0;
    end else if (en_i) begin
      crc_d = {crc_q[5:0], 1'b0} ^ (w_fb ? c_CRC7_POLY : 7'd0);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sdhci_cmd_ctrl.sv
// ============================================================================
// Module : sdhci_cmd_ctrl
// Brief  : SD CMD line sequencer - frame transmit, response wait/receive/check.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sdhci_cmd_ctrl
  import sdhci_pkg::*;
#(
  parameter int TIMEOUT_TICKS = 64,
  parameter int NCC_TICKS     = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         sd_tick_i,
  input  logic         abort_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [5:0]   req_index_i,
  input  logic [31:0]  req_arg_i,
  input  logic [1:0]   req_rsp_type_i,
  output logic         rsp_valid_o,
  output logic [135:0] rsp_data_o,
  output logic         rsp_timeout_o,
  output logic         rsp_crc_err_o,
  output logic         rsp_index_err_o,
  output logic         rsp_end_err_o,
  output logic         cmd_en_o,
  output logic         cmd_o,
  input  logic         cmd_i
);

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_SEND = 3'd1;
  localparam logic [2:0] c_ST_WAIT = 3'd2;
  localparam logic [2:0] c_ST_RECV = 3'd3;
  localparam logic [2:0] c_ST_NCC  = 3'd4;
  localparam int         c_CW      = 16;

  logic [2:0]      state_q, state_d;
  logic [7:0]      bit_cnt_q, bit_cnt_d;
  logic [c_CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [39:0]     tx_q, tx_d;
  logic [135:0]    rx_q, rx_d;
  logic [5:0]      idx_q, idx_d;
  rsp_type_e       type_q, type_d;
  logic            cmd_en_q, cmd_en_d, cmd_q, cmd_d, valid_q, valid_d;
  logic            tout_q, tout_d, crc_err_q, crc_err_d;
  logic            idx_err_q, idx_err_d, end_err_q, end_err_d;

  logic            w_accept, w_tx_bit, w_last;
  logic            w_crc_clr, w_crc_en, w_crc_bit;
  logic [6:0]      w_crc;
  logic [135:0]    w_rx_shift;

  assign req_ready_o     = (state_q == c_ST_IDLE);
  assign w_accept        = req_ready_o && req_valid_i && !abort_i;
  assign w_rx_shift      = {rx_q[134:0], cmd_i};
  assign w_last          = (type_q == RSP_R136) ? (bit_cnt_q == 8'(c_R136_FRAME_LEN - 1))
                                                : (bit_cnt_q == 8'(c_CMD_FRAME_LEN - 1));
  assign rsp_valid_o     = valid_q;
  assign rsp_data_o      = rx_q;
  assign rsp_timeout_o   = tout_q;
  assign rsp_crc_err_o   = crc_err_q;
  assign rsp_index_err_o = idx_err_q;
  assign rsp_end_err_o   = end_err_q;
  assign cmd_en_o        = cmd_en_q;
  assign cmd_o           = cmd_q;

  // Payload bits come from the shifter, then the CRC, then the end bit.
  always_comb begin
    w_tx_bit = 1'b1;
    if (bit_cnt_q < 8'(c_CRC_BITS)) begin
      w_tx_bit = tx_q[39];
    end else if (bit_cnt_q < 8'(c_CMD_FRAME_LEN - 1)) begin
      w_tx_bit = w_crc[3'(8'(c_CMD_FRAME_LEN - 2) - bit_cnt_q)];
    end
  end

  // R48 CRC covers the start bit onward; R136 skips the 8-bit header.
  always_comb begin
    w_crc_clr = w_accept;
    w_crc_en  = 1'b0;
    w_crc_bit = cmd_i;
    if (sd_tick_i && !abort_i) begin
      case (state_q)
        c_ST_SEND: begin
          w_crc_bit = tx_q[39];
          w_crc_en  = (bit_cnt_q < 8'(c_CRC_BITS));
          w_crc_clr = (bit_cnt_q == 8'(c_CMD_FRAME_LEN));
        end
        c_ST_WAIT: w_crc_en = !cmd_i && (type_q != RSP_R136);
        c_ST_RECV: w_crc_en = (type_q == RSP_R136)
                            ? ((bit_cnt_q >= 8'd8) && (bit_cnt_q < 8'(c_R136_FRAME_LEN - 8)))
                            : (bit_cnt_q < 8'(c_CRC_BITS));
        default:   w_crc_en = 1'b0;
      endcase
    end
  end

  sdhci_crc7 u_crc7 (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (w_crc_clr),
    .en_i    (w_crc_en),
    .bit_i   (w_crc_bit),
    .crc_o   (w_crc)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tick_cnt_d = tick_cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    idx_d      = idx_q;
    type_d     = type_q;
    cmd_en_d   = cmd_en_q;
    cmd_d      = cmd_q;
    valid_d    = 1'b0;
    tout_d     = tout_q;
    crc_err_d  = crc_err_q;
    idx_err_d  = idx_err_q;
    end_err_d  = end_err_q;
    if (abort_i) begin
      state_d    = c_ST_IDLE;
      bit_cnt_d  = '0;
      tick_cnt_d = '0;
      cmd_en_d   = 1'b0;
      cmd_d      = 1'b1;
    end else if (w_accept) begin
      state_d    = c_ST_SEND;
      bit_cnt_d  = '0;
      tick_cnt_d = '0;
      tx_d       = {2'b01, req_index_i, req_arg_i};
      idx_d      = req_index_i;
      type_d     = rsp_type_e'(req_rsp_type_i);
      rx_d       = '0;
      tout_d     = 1'b0;
      crc_err_d  = 1'b0;
      idx_err_d  = 1'b0;
      end_err_d  = 1'b0;
    end else if (sd_tick_i) begin
      case (state_q)
        c_ST_SEND: begin
          if (bit_cnt_q == 8'(c_CMD_FRAME_LEN)) begin
            cmd_en_d   = 1'b0;
            cmd_d      = 1'b1;
            bit_cnt_d  = '0;
            tick_cnt_d = '0;
            if (type_q == RSP_NONE) begin
              state_d = c_ST_NCC;
              valid_d = 1'b1;
            end else begin
              state_d = c_ST_WAIT;
            end
          end else begin
            cmd_en_d  = 1'b1;
            cmd_d     = w_tx_bit;
            bit_cnt_d = bit_cnt_q + 8'd1;
            tx_d      = {tx_q[38:0], 1'b0};
          end
        end
        c_ST_WAIT: begin
          if (!cmd_i) begin
            rx_d      = w_rx_shift;
            bit_cnt_d = 8'd1;
            state_d   = c_ST_RECV;
          end else if (tick_cnt_q == c_CW'(TIMEOUT_TICKS - 1)) begin
            tout_d     = 1'b1;
            tick_cnt_d = '0;
            state_d    = c_ST_NCC;
            valid_d    = 1'b1;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        c_ST_RECV: begin
          rx_d      = w_rx_shift;
          bit_cnt_d = bit_cnt_q + 8'd1;
          if (w_last) begin
            end_err_d  = !cmd_i;
            crc_err_d  = (type_q != RSP_R48_NOCRC) && (w_crc != w_rx_shift[7:1]);
            idx_err_d  = (type_q == RSP_R48) && (w_rx_shift[45:40] != idx_q);
            bit_cnt_d  = '0;
            tick_cnt_d = '0;
            state_d    = c_ST_NCC;
            valid_d    = 1'b1;
          end
        end
        c_ST_NCC: begin
          if (tick_cnt_q == c_CW'(NCC_TICKS - 1)) begin
            tick_cnt_d = '0;
            state_d    = c_ST_IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
        default: state_d = c_ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= c_ST_IDLE;
      bit_cnt_q  <= '0;
      tick_cnt_q <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      idx_q      <= '0;
      type_q     <= RSP_NONE;
      cmd_en_q   <= 1'b0;
      cmd_q      <= 1'b1;
      valid_q    <= 1'b0;
      tout_q     <= 1'b0;
      crc_err_q  <= 1'b0;
      idx_err_q  <= 1'b0;
      end_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      idx_q      <= idx_d;
      type_q     <= type_d;
      cmd_en_q   <= cmd_en_d;
      cmd_q      <= cmd_d;
      valid_q    <= valid_d;
      tout_q     <= tout_d;
      crc_err_q  <= crc_err_d;
      idx_err_q  <= idx_err_d;
      end_err_q  <= end_err_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sdhci_cmd_ctrl.sv
// ============================================================================
// Module : tb_sdhci_cmd_ctrl
// Brief  : Directed vector bench for the SD CMD line controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sdhci_cmd_ctrl;

  localparam int TIMEOUT = 64;
  localparam int NCC     = 8;

  logic         clk = 1'b0;
  logic         rst, sd_tick, abort, req_valid, req_ready, rsp_valid;
  logic [5:0]   req_index;
  logic [31:0]  req_arg;
  logic [1:0]   req_type;
  logic [135:0] rsp_data;
  logic         rsp_tout, rsp_crc, rsp_idx, rsp_end, cmd_en, cmd_out, cmd_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sdhci_cmd_ctrl #(.TIMEOUT_TICKS(TIMEOUT), .NCC_TICKS(NCC)) dut (
    .clk_i(clk), .rst_i(rst), .sd_tick_i(sd_tick), .abort_i(abort),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_index_i(req_index),
    .req_arg_i(req_arg), .req_rsp_type_i(req_type), .rsp_valid_o(rsp_valid),
    .rsp_data_o(rsp_data), .rsp_timeout_o(rsp_tout), .rsp_crc_err_o(rsp_crc),
    .rsp_index_err_o(rsp_idx), .rsp_end_err_o(rsp_end), .cmd_en_o(cmd_en),
    .cmd_o(cmd_out), .cmd_i(cmd_in)
  );

  typedef struct {
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   rtype;
    int           delay;     // ticks of idle line before the start bit; -1 = no answer
    int           gate_at;   // SEND bit before which the tick is held off; 0 = never
    logic [135:0] rsp;       // card frame, LSB = end bit
    logic [47:0]  exp_tx;
    logic [3:0]   exp_flags; // {timeout, crc, index, end}
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] crc7_of(input logic [119:0] d, input int n);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = n - 1; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  function automatic logic [135:0] mk_r48(input logic [39:0] p);
    logic [135:0] f;
    f       = '0;
    f[47:0] = {p, crc7_of({80'd0, p}, 40), 1'b1};
    return f;
  endfunction

  function automatic logic [135:0] mk_r136(input logic [119:0] p);
    return {8'h3F, p, crc7_of(p, 120), 1'b1};
  endfunction

  task automatic tick();
    @(negedge clk); sd_tick = 1'b1;
    @(negedge clk); sd_tick = 1'b0;
  endtask

  task automatic issue(input logic [5:0] idx, input logic [31:0] arg,
                       input logic [1:0] t, input string nm);
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_index = idx; req_arg = arg; req_type = t;
    @(negedge clk);
    req_valid = 1'b0;
    chk({nm, "_busy"}, req_ready, 1'b0);
    chk({nm, "_clr"}, {rsp_data, rsp_tout, rsp_crc, rsp_idx, rsp_end}, '0);
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    logic [47:0] tx;
    logic        en_all, early;
    int          len, n;
    len    = (v.rtype == 2'd3) ? 136 : 48;
    en_all = 1'b1;
    early  = 1'b0;
    issue(v.idx, v.arg, v.rtype, nm);
    for (int i = 0; i < 48; i++) begin
      if (v.gate_at != 0 && i == v.gate_at) begin
        req_valid = 1'b1; req_index = 6'h3F;
        repeat (10) @(negedge clk);
        req_valid = 1'b0;
        chk({nm, "_gate_hold"}, {cmd_en, cmd_out}, {1'b1, v.exp_tx[48 - i]});
      end
      tick();
      tx[47 - i] = cmd_out;
      en_all     = en_all & cmd_en;
    end
    chk({nm, "_tx"}, tx, v.exp_tx);
    chk({nm, "_tx_en"}, en_all, 1'b1);
    tick();
    chk({nm, "_release"}, {cmd_en, cmd_out}, 2'b01);
    if (v.rtype != 2'd0) begin
      if (v.delay < 0) begin
        n = 0;
        while (!rsp_valid && n < 200) begin
          tick();
          n++;
        end
        chk({nm, "_tout_ticks"}, n, TIMEOUT);
      end else begin
        repeat (v.delay) begin
          tick();
          early = early | rsp_valid;
        end
        for (int i = 0; i < len; i++) begin
          cmd_in = v.rsp[len - 1 - i];
          tick();
          if (i < len - 1) early = early | rsp_valid;
        end
        cmd_in = 1'b1;
        chk({nm, "_early"}, early, 1'b0);
      end
    end
    chk({nm, "_valid"}, rsp_valid, 1'b1);
    chk({nm, "_data"}, rsp_data, (v.rtype != 2'd0 && v.delay >= 0) ? v.rsp : 136'd0);
    chk({nm, "_flags"}, {rsp_tout, rsp_crc, rsp_idx, rsp_end}, v.exp_flags);
    @(negedge clk);
    chk({nm, "_pulse"}, rsp_valid, 1'b0);
    repeat (NCC - 1) tick();
    chk({nm, "_ncc_busy"}, req_ready, 1'b0);
    tick();
    chk({nm, "_ncc_done"}, req_ready, 1'b1);
    chk({nm, "_hold"}, {rsp_tout, rsp_crc, rsp_idx, rsp_end}, v.exp_flags);
  endtask

  // stage: 0 = SEND, 1 = WAIT, 2 = RECV
  task automatic cut_txn(input int stage, input bit use_rst, input string nm);
    logic seen;
    issue(6'd8, 32'h1AA, 2'd1, nm);
    repeat ((stage == 0) ? 20 : 49) tick();
    if (stage == 0) chk({nm, "_driving"}, cmd_en, 1'b1);
    if (stage >= 1) begin
      cmd_in = (stage == 2) ? 1'b0 : 1'b1;
      tick();
      cmd_in = 1'b1;
    end
    if (stage == 2) repeat (10) tick();
    chk({nm, "_inflight"}, req_ready, 1'b0);
    @(negedge clk);
    if (use_rst) begin
      rst = 1'b1;
      #1;
      chk({nm, "_async_rel"}, {cmd_en, cmd_out}, 2'b01);
      @(negedge clk);
      rst = 1'b0;
    end else begin
      abort = 1'b1; sd_tick = 1'b1;
      @(negedge clk);
      abort = 1'b0; sd_tick = 1'b0;
    end
    chk({nm, "_cut"}, {cmd_en, cmd_out, req_ready, rsp_valid}, 4'b0110);
    seen = 1'b0;
    repeat (TIMEOUT + 10) begin
      tick();
      seen = seen | rsp_valid;
    end
    chk({nm, "_no_pulse"}, seen, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sd_tick = 1'b0; abort = 1'b0; req_valid = 1'b0;
    req_index = '0; req_arg = '0; req_type = '0; cmd_in = 1'b1;

    vecs[0] = '{6'd0, 32'h0,   2'd0,  0,  0, 136'd0,                   48'h40_0000_0000_95, 4'b0000};
    vecs[1] = '{6'd8, 32'h1AA, 2'd1,  2,  0, 136'h08_0000_01AA_13,     48'h48_0000_01AA_87, 4'b0000};
    vecs[2] = '{6'd8, 32'h1AA, 2'd1,  2,  0, 136'h08_0000_01AA_15,     48'h48_0000_01AA_87, 4'b0100};
    vecs[3] = '{6'd8, 32'h1AA, 2'd1,  2,  0, mk_r48(40'h09_0000_01AA), 48'h48_0000_01AA_87, 4'b0010};
    vecs[4] = '{6'd8, 32'h1AA, 2'd1, -1,  0, 136'd0,                   48'h48_0000_01AA_87, 4'b1000};
    vecs[5] = '{6'd8, 32'h1AA, 2'd2,  3,  0, 136'h3F_80FF_8000_FF,     48'h48_0000_01AA_87, 4'b0000};
    vecs[6] = '{6'd8, 32'h1AA, 2'd3,  1,  0,
                mk_r136(120'h0353_4453_4430_3180_0012_3456_7801_4B), 48'h48_0000_01AA_87, 4'b0000};
    vecs[7] = '{6'd8, 32'h1AA, 2'd1,  0,  0, 136'h08_0000_01AA_12,     48'h48_0000_01AA_87, 4'b0001};
    vecs[8] = '{6'd0, 32'h0,   2'd0,  0, 10, 136'd0,                   48'h40_0000_0000_95, 4'b0000};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", {req_ready, cmd_en, cmd_out, rsp_valid}, 4'b1010);
    chk("reset_data", rsp_data, 136'd0);
    chk("reset_flags", {rsp_tout, rsp_crc, rsp_idx, rsp_end}, 4'b0000);

    for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("v%0d", i));

    cut_txn(0, 1'b0, "abort_send");
    cut_txn(1, 1'b0, "abort_wait");
    cut_txn(2, 1'b0, "abort_recv");
    cut_txn(0, 1'b1, "rst_send");
    cut_txn(2, 1'b1, "rst_recv");
    run_txn(vecs[1], "after_cut");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
